// File: rtl/cpu_memory_loader.sv
// cpu_memory_loader: length-prefixed byte-stream ROM loader writing CHIP-8 memory port A.
// Optional feature: define LOADER_CLEAR_EN to zero-fill memory above the payload after a load.
module cpu_memory_loader #(
  parameter logic [11:0] BASE_ADDR = 12'h200,
  parameter logic [11:0] MEM_TOP   = 12'hFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        mem_en,
  output logic        mem_write,
  output logic [11:0] mem_addr,
  output logic [7:0]  mem_data,
  output logic        cpu_hold,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam logic [15:0] MaxLen = {4'h0, MEM_TOP} - {4'h0, BASE_ADDR} + 16'd1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
`ifdef LOADER_CLEAR_EN
    S_CLEAR,
`endif
    S_FIN,
    S_ERR
  } state_t;

  state_t      r_state;
  state_t      w_nextState;
  logic [7:0]  r_lenHi;
  logic [11:0] r_ptr;
  logic [15:0] r_remaining;
  logic        r_memEn;
  logic        r_memWrite;
  logic [11:0] r_memAddr;
  logic [7:0]  r_memData;
  logic        r_cpuHold;
  logic        r_busy;
  logic        r_done;
  logic        r_error;
  logic        w_ready;
  logic        w_accept;
  logic [15:0] w_len;

  assign w_ready  = (r_state == S_LEN_HI) || (r_state == S_LEN_LO) || (r_state == S_DATA);
  assign w_accept = in_valid && w_ready;
  assign w_len    = {r_lenHi, in_data};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE, S_FIN, S_ERR: begin
        if (start) w_nextState = S_LEN_HI;
      end
      S_LEN_HI: begin
        if (w_accept) w_nextState = S_LEN_LO;
      end
      S_LEN_LO: begin
        if (w_accept) begin
          if (w_len > MaxLen) begin
            w_nextState = S_ERR;
          end else if (w_len == 16'd0) begin
`ifdef LOADER_CLEAR_EN
            w_nextState = S_CLEAR;
`else
            w_nextState = S_FIN;
`endif
          end else begin
            w_nextState = S_DATA;
          end
        end
      end
      S_DATA: begin
        // A payload that ends exactly at MEM_TOP leaves nothing to clear.
        if (w_accept && (r_remaining == 16'd1)) begin
`ifdef LOADER_CLEAR_EN
          w_nextState = (r_ptr == MEM_TOP) ? S_FIN : S_CLEAR;
`else
          w_nextState = S_FIN;
`endif
        end
      end
`ifdef LOADER_CLEAR_EN
      S_CLEAR: begin
        if (r_ptr == MEM_TOP) w_nextState = S_FIN;
      end
`endif
      default: w_nextState = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lenHi     <= 8'd0;
      r_ptr       <= 12'd0;
      r_remaining <= 16'd0;
      r_memEn     <= 1'b0;
      r_memWrite  <= 1'b0;
      r_memAddr   <= 12'd0;
      r_memData   <= 8'd0;
      r_cpuHold   <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_memEn    <= 1'b0;
      r_memWrite <= 1'b0;
      case (r_state)
        S_IDLE, S_FIN, S_ERR: begin
          // start wins over the resting-state status updates
          if (start) begin
            r_done    <= 1'b0;
            r_error   <= 1'b0;
            r_cpuHold <= 1'b1;
            r_busy    <= 1'b1;
          end else if (r_state == S_FIN) begin
            r_done    <= 1'b1;
            r_cpuHold <= 1'b0;
            r_busy    <= 1'b0;
          end else if (r_state == S_ERR) begin
            r_error <= 1'b1;
            r_busy  <= 1'b0;
          end
        end
        S_LEN_HI: begin
          if (w_accept) r_lenHi <= in_data;
        end
        S_LEN_LO: begin
          if (w_accept) begin
            r_ptr       <= BASE_ADDR;
            r_remaining <= w_len;
          end
        end
        S_DATA: begin
          if (w_accept) begin
            r_memEn     <= 1'b1;
            r_memWrite  <= 1'b1;
            r_memAddr   <= r_ptr;
            r_memData   <= in_data;
            r_ptr       <= r_ptr + 12'd1;
            r_remaining <= r_remaining - 16'd1;
          end
        end
`ifdef LOADER_CLEAR_EN
        S_CLEAR: begin
          r_memEn    <= 1'b1;
          r_memWrite <= 1'b1;
          r_memAddr  <= r_ptr;
          r_memData  <= 8'h00;
          r_ptr      <= r_ptr + 12'd1;
        end
`endif
        default: ;
      endcase
    end
  end

  assign in_ready  = w_ready;
  assign mem_en    = r_memEn;
  assign mem_write = r_memWrite;
  assign mem_addr  = r_memAddr;
  assign mem_data  = r_memData;
  assign cpu_hold  = r_cpuHold;
  assign busy      = r_busy;
  assign done      = r_done;
  assign error     = r_error;

endmodule
